// File: rtl/switch_box_pkg.sv
// Shared constants and sizing helpers for the parametrised switch box.
package switch_box_pkg;

  localparam int SIDES = 4;
  localparam int SEL_W = 2;

  // Number of config words needed to hold one select field per output.
  function automatic int cfg_words(input int num_tracks, input int data_w);
    return (SIDES * num_tracks * SEL_W + data_w - 1) / data_w;
  endfunction

  // Word address width; never narrower than one bit.
  function automatic int cfg_addr_w(input int words);
    return (words <= 2) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/switch_box_cfg_bank.sv
// Double-buffered configuration store: shadow bank written word by word,
// active bank loaded from shadow on commit, plus readback and status.
module switch_box_cfg_bank
  import switch_box_pkg::*;
#(
  parameter  int NUM_TRACKS = 8,
  parameter  int CFG_DATA_W = 32,
  localparam int CFG_BITS   = SIDES * NUM_TRACKS * SEL_W,
  localparam int CFG_WORDS  = cfg_words(NUM_TRACKS, CFG_DATA_W),
  localparam int CFG_ADDR_W = cfg_addr_w(CFG_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_wr_en,
  input  logic [CFG_ADDR_W-1:0] cfg_addr,
  input  logic [CFG_DATA_W-1:0] cfg_wdata,
  input  logic                  cfg_commit,
  input  logic [CFG_ADDR_W-1:0] cfg_rd_addr,
  output logic [CFG_DATA_W-1:0] cfg_rd_data,
  output logic                  cfg_dirty,
  output logic                  cfg_err,
  output logic [CFG_BITS-1:0]   active
);

  localparam int PAD_BITS = CFG_WORDS * CFG_DATA_W;
  // Keeps bits past CFG_BITS at zero so the last word reads back clean.
  localparam logic [PAD_BITS-1:0] PAD_MASK = PAD_BITS'({CFG_BITS{1'b1}});

  logic [CFG_BITS-1:0]   shadow, shadow_nxt;
  logic [PAD_BITS-1:0]   wr_pad, nxt_pad;
  logic [CFG_DATA_W-1:0] rd_word;
  logic                  wr_ok, rd_ok;

  // Post-write shadow image and the readback word taken from it.
  always_comb begin
    wr_ok   = 32'(cfg_addr) < 32'(CFG_WORDS);
    rd_ok   = 32'(cfg_rd_addr) < 32'(CFG_WORDS);
    wr_pad  = PAD_BITS'(shadow);
    if (cfg_wr_en && wr_ok)
      wr_pad[int'(cfg_addr)*CFG_DATA_W +: CFG_DATA_W] = cfg_wdata;
    nxt_pad    = wr_pad & PAD_MASK;
    shadow_nxt = nxt_pad[CFG_BITS-1:0];
    rd_word    = rd_ok ? nxt_pad[int'(cfg_rd_addr)*CFG_DATA_W +: CFG_DATA_W] : '0;
  end

  // Bank registers; commit copies the post-write shadow so a same-cycle
  // write is included and dirty always clears.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow      <= '0;
      active      <= '0;
      cfg_rd_data <= '0;
      cfg_dirty   <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      shadow      <= shadow_nxt;
      cfg_rd_data <= rd_word;
      cfg_err     <= cfg_wr_en && !wr_ok;
      if (cfg_commit) begin
        active    <= shadow_nxt;
        cfg_dirty <= 1'b0;
      end else if (cfg_wr_en && wr_ok) begin
        cfg_dirty <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_box_param.sv
// Parametrised 4-sided switch box: each output picks one side's same-numbered
// track through a 4:1 mux steered by its field in the active config bank.
module switch_box_param
  import switch_box_pkg::*;
#(
  parameter  int NUM_TRACKS = 8,
  parameter  int CFG_DATA_W = 32,
  parameter  int REG_OUT    = 1,
  localparam int CFG_ADDR_W = cfg_addr_w(cfg_words(NUM_TRACKS, CFG_DATA_W))
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_wr_en,
  input  logic [CFG_ADDR_W-1:0]         cfg_addr,
  input  logic [CFG_DATA_W-1:0]         cfg_wdata,
  input  logic                          cfg_commit,
  input  logic [CFG_ADDR_W-1:0]         cfg_rd_addr,
  output logic [CFG_DATA_W-1:0]         cfg_rd_data,
  output logic                          cfg_dirty,
  output logic                          cfg_err,
  input  logic [SIDES*NUM_TRACKS-1:0]   track_in,
  output logic [SIDES*NUM_TRACKS-1:0]   track_out
);

  localparam int N_OUT    = SIDES * NUM_TRACKS;
  localparam int CFG_BITS = N_OUT * SEL_W;

  logic [CFG_BITS-1:0] active;
  logic [N_OUT-1:0]    routed;

  switch_box_cfg_bank #(
    .NUM_TRACKS (NUM_TRACKS),
    .CFG_DATA_W (CFG_DATA_W)
  ) u_bank (
    .clk         (clk),
    .rst         (rst),
    .cfg_wr_en   (cfg_wr_en),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .cfg_commit  (cfg_commit),
    .cfg_rd_addr (cfg_rd_addr),
    .cfg_rd_data (cfg_rd_data),
    .cfg_dirty   (cfg_dirty),
    .cfg_err     (cfg_err),
    .active      (active)
  );

  for (genvar s = 0; s < SIDES; s++) begin : g_side
    for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_trk
      logic [SIDES-1:0] cand;
      logic [SEL_W-1:0] sel;
      assign sel = active[SEL_W*(s*NUM_TRACKS+t) +: SEL_W];
      // Candidates are track t on every side; no cross-track permutation.
      for (genvar k = 0; k < SIDES; k++) begin : g_cand
        assign cand[k] = track_in[k*NUM_TRACKS+t];
      end
      assign routed[s*NUM_TRACKS+t] = cand[sel];
    end
  end

  if (REG_OUT != 0) begin : g_reg
    // Output register; a fresh commit shows up one edge after the commit edge.
    always_ff @(posedge clk) begin
      if (!rst) track_out <= '0;
      else      track_out <= routed;
    end
  end else begin : g_comb
    assign track_out = routed;
  end

endmodule

// File: tb/tb_switch_box_param.sv
// Bench for switch_box_param: behavioural model checked every cycle on the
// 8-track/32-bit registered build, plus directed checks on a 5-track/16-bit
// combinational build that has an out-of-range address and a partial word.
module tb_switch_box_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, commit;
  logic [0:0]  addr, rd_addr;
  logic [31:0] wdata, rd_data, tin, tout;
  logic        dirty, err;

  logic        b_wr, b_commit;
  logic [1:0]  b_addr, b_rd_addr;
  logic [15:0] b_wdata, b_rd;
  logic        b_dirty, b_err;
  logic [19:0] b_tin, b_tout;

  int ncmp = 0;
  int nbad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  switch_box_param #(.NUM_TRACKS(8), .CFG_DATA_W(32), .REG_OUT(1)) dut (
    .clk(clk), .rst(rst), .cfg_wr_en(wr_en), .cfg_addr(addr), .cfg_wdata(wdata),
    .cfg_commit(commit), .cfg_rd_addr(rd_addr), .cfg_rd_data(rd_data),
    .cfg_dirty(dirty), .cfg_err(err), .track_in(tin), .track_out(tout)
  );

  switch_box_param #(.NUM_TRACKS(5), .CFG_DATA_W(16), .REG_OUT(0)) dut2 (
    .clk(clk), .rst(rst), .cfg_wr_en(b_wr), .cfg_addr(b_addr), .cfg_wdata(b_wdata),
    .cfg_commit(b_commit), .cfg_rd_addr(b_rd_addr), .cfg_rd_data(b_rd),
    .cfg_dirty(b_dirty), .cfg_err(b_err), .track_in(b_tin), .track_out(b_tout)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Output (s,t) takes side k's track t, k being its 2-bit field.
  function automatic logic [31:0] route(input logic [63:0] act, input logic [31:0] ti);
    logic [31:0] o;
    o = '0;
    for (int s = 0; s < 4; s++)
      for (int t = 0; t < 8; t++) begin
        int k;
        k = int'(act[2*(s*8+t) +: 2]);
        o[s*8+t] = ti[k*8+t];
      end
    return o;
  endfunction

  // Model state: shadow/active banks and expected registered outputs.
  logic [63:0] m_sh, m_act;
  logic [31:0] m_out, m_rd;
  logic        m_dirty, m_err;

  always @(posedge clk) begin
    if (!rst) begin
      m_sh = '0; m_act = '0; m_out = '0; m_rd = '0; m_dirty = 1'b0; m_err = 1'b0;
    end else begin
      m_out = route(m_act, tin);
      m_err = 1'b0;                      // 1-bit address: every word is in range
      if (wr_en) begin
        m_sh[int'(addr)*32 +: 32] = wdata;
        m_dirty = 1'b1;
      end
      if (commit) begin
        m_act   = m_sh;
        m_dirty = 1'b0;
      end
      m_rd = m_sh[int'(rd_addr)*32 +: 32];
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model track_out", {32'h0, tout}, {32'h0, m_out});
      chk("model rd_data", {32'h0, rd_data}, {32'h0, m_rd});
      chk("model dirty", {63'h0, dirty}, {63'h0, m_dirty});
      chk("model err", {63'h0, err}, {63'h0, m_err});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0; commit = 1'b0; rd_addr = '0;
    tin = 32'hA5A5_5A5A;
    b_wr = 1'b0; b_addr = '0; b_wdata = '0; b_commit = 1'b0; b_rd_addr = '0; b_tin = '0;

    // Reset held two cycles, then release: side-0 loopback everywhere.
    step; chk_on = 1'b1; step;
    chk("reset track_out", {32'h0, tout}, 64'h0);
    rst = 1'b1; step;
    chk("loopback", {32'h0, tout}, 64'h5A5A_5A5A);
    chk("reset dirty", {63'h0, dirty}, 64'h0);
    chk("reset err", {63'h0, err}, 64'h0);
    chk("reset rd_data", {32'h0, rd_data}, 64'h0);

    // Shadow write without commit leaves routing alone.
    wr_en = 1'b1; addr = 1'b0; wdata = 32'h5555_5555; rd_addr = 1'b0; step;
    wr_en = 1'b0; tin = 32'h1234_5678; step;
    chk("isolated route", {32'h0, tout}, 64'h7878_7878);
    chk("isolated dirty", {63'h0, dirty}, 64'h1);
    chk("readback w0", {32'h0, rd_data}, 64'h5555_5555);

    // Commit latency: all fields -> side 1.
    wr_en = 1'b1; addr = 1'b1; step;
    wr_en = 1'b0; commit = 1'b1; tin = 32'h0000_C300; step;
    chk("old route at commit", {32'h0, tout}, 64'h0);
    chk("commit dirty", {63'h0, dirty}, 64'h0);
    commit = 1'b0; step;
    chk("new route", {32'h0, tout}, 64'hC3C3_C3C3);

    // Same-cycle write + commit: sides 2/3 select side 3.
    wr_en = 1'b1; addr = 1'b1; wdata = 32'hFFFF_FFFF; commit = 1'b1; tin = 32'h3C99_C311; step;
    chk("wr+commit dirty", {63'h0, dirty}, 64'h0);
    chk("wr+commit old route", {32'h0, tout}, 64'hC3C3_C3C3);
    wr_en = 1'b0; commit = 1'b0; step;
    chk("wr+commit route", {32'h0, tout}, 64'h3C3C_C3C3);
    rd_addr = 1'b1; step;
    chk("readback w1", {32'h0, rd_data}, 64'hFFFF_FFFF);

    // Commit held several cycles with a write in the middle.
    commit = 1'b1; step;
    wr_en = 1'b1; addr = 1'b0; wdata = 32'hAAAA_AAAA; step;
    wr_en = 1'b0; step;
    commit = 1'b0; step;
    chk("held commit route", {32'h0, tout}, 64'h3C3C_9999);

    // Reset lands on a write+commit cycle: both discarded.
    wr_en = 1'b1; addr = 1'b0; wdata = 32'h0F0F_0F0F; commit = 1'b1; rst = 1'b0; step;
    wr_en = 1'b0; commit = 1'b0; rst = 1'b1; step;
    chk("mid-reprogram reset route", {32'h0, tout}, 64'h1111_1111);
    chk("mid-reprogram reset rd", {32'h0, rd_data}, 64'h0);

    // Mixed traffic, model-checked each cycle.
    for (int i = 0; i < 60; i++) begin
      wr_en   = ($urandom_range(0, 1) == 1);
      addr    = 1'($urandom_range(0, 1));
      wdata   = $urandom;
      commit  = ($urandom_range(0, 3) == 0);
      rd_addr = 1'($urandom_range(0, 1));
      tin     = $urandom;
      rst     = ($urandom_range(0, 31) != 0);
      step;
    end
    rst = 1'b1; wr_en = 1'b0; commit = 1'b0; step;

    // 5-track/16-bit combinational build: 3 words, last holds 8 bits.
    b_wr = 1'b1; b_addr = 2'd3; b_wdata = 16'hFFFF; step;
    chk("oor err pulse", {63'h0, b_err}, 64'h1);
    chk("oor dirty", {63'h0, b_dirty}, 64'h0);
    b_wr = 1'b0; step;
    chk("oor err clears", {63'h0, b_err}, 64'h0);
    chk("oor shadow w0", {48'h0, b_rd}, 64'h0);
    b_wr = 1'b1; b_addr = 2'd2; b_rd_addr = 2'd2; step;
    chk("partial word rd", {48'h0, b_rd}, 64'h00FF);
    chk("partial word dirty", {63'h0, b_dirty}, 64'h1);
    b_wr = 1'b0; b_commit = 1'b1; step;
    chk("b commit dirty", {63'h0, b_dirty}, 64'h0);
    b_commit = 1'b0; b_tin = 20'hC83F6; #1;
    chk("comb route", {44'h0, b_tout}, 64'hC5AD6);
    b_rd_addr = 2'd3; step;
    chk("oor rd", {48'h0, b_rd}, 64'h0);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
